serial_sum_packer: RTL
======================

SERIAL_SUM_PACKER -- requirements
Module: serial_sum_packer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the bits per packed word (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port bit_valid, input, 1, upstream sum/carry pair present this cycle.
REQ-005 SHALL have port a_in, input, 1, sum bit from the upstream serial adder stage.
REQ-006 SHALL have port cout_in, input, 1, carry bit from the upstream serial adder stage.
REQ-007 SHALL have port out_ready, input, 1, downstream accepts the word.
REQ-008 SHALL have port out_valid, output, 1, a packed word is held.
REQ-009 SHALL have port out_word, output, WIDTH, packed sum bits, first accepted bit in bit 0.
REQ-010 SHALL have port out_carries, output, $clog2(WIDTH+1), count of cout_in=1 within the word.
REQ-011 SHALL have port overflow, output, 1, sticky: an input bit was dropped.

Function
REQ-012 SHALL implement FSM states IDLE, FILL and HOLD, encoded in a 2-bit register.
REQ-013 SHALL accept a bit when bit_valid=1 in IDLE or FILL: a_in is written to out_word[cnt], out_carries increments if cout_in=1, and cnt increments.
REQ-014 SHALL move IDLE->FILL on the first accepted bit when WIDTH>1.
REQ-015 SHALL move to HOLD on the bit accepted at cnt=WIDTH-1, with out_valid=1 from the next cycle.
REQ-016 SHALL hold out_word and out_carries stable in HOLD until out_ready=1, i.e. until the transfer.
REQ-017 SHALL, on transfer with bit_valid=0, go to IDLE, clear cnt and clear out_carries.
REQ-018 SHALL, on transfer with bit_valid=1 in the same cycle, start the new word with that bit: cnt=1, out_carries=cout_in, state FILL.
REQ-019 SHALL, on bit_valid=1 in HOLD without out_ready, drop the bit and set overflow=1 next cycle; the held word is unchanged.
REQ-020 SHALL leave unwritten out_word bits of a partial word at 0.
REQ-021 SHALL keep out_valid as a pure registered decode of state==HOLD, with 1-cycle latency from the last accepted bit.
REQ-022 SHALL contain, under ifdef FORMAL: assert cnt<WIDTH; assert out_valid==(state==HOLD); assert out_carries<=cnt (or <=WIDTH in HOLD); assume bit_valid==0 while rst_n==0; a restrict property that out_ready does not toggle while out_valid is 0; an (* anyconst *) bit index checked against out_word.

Reset
REQ-023 SHALL, when rst_n=0, asynchronously force state=IDLE, cnt=0, out_word=0, out_carries=0, out_valid=0 and overflow=0.
REQ-024 SHALL discard a partially filled or held word when reset is asserted mid-operation; no transfer is reported.
REQ-025 SHALL clear overflow only by reset.

Structure
REQ-026 SHALL put the state encoding (IDLE=0, FILL=1, HOLD=2) and the default WIDTH in a shared package, serial_sum_pkg.
REQ-027 SHALL use at most one sub-module, bit_counter (a saturating cnt with clear, load and increment); otherwise the block is flat.
REQ-028 SHALL be synthesizable by Yosys read_verilog -sv with and without -formal.

Verification
REQ-029 SHALL cover a basic fill: WIDTH=8, eight bits a_in=1,0,1,1,0,0,1,0 with cout_in=1 on bits 0 and 3 -> out_valid=1 next cycle, out_word=8'h4D, out_carries=2.
REQ-030 SHALL cover back-to-back words: out_ready=1 together with bit_valid=1 in HOLD -> next word cnt=1, no bit lost, and overflow stays 0.
REQ-031 SHALL cover backpressure: out_ready=0 and 3 extra bits in HOLD -> out_word unchanged and overflow=1 from the cycle after the first dropped bit.
REQ-032 SHALL cover reset mid-fill: rst_n low after 5 bits -> all outputs 0 immediately, and a new fill produces a correct word.
REQ-033 SHALL cover all-carries: eight bits with cout_in=1 -> out_carries=8, with no wrap.
REQ-034 SHALL pass a SymbiYosys prove, depth 20, with all REQ-022 assertions holding.

Source files
------------

// File: rtl/serial_sum_pkg.sv
// Shared definitions for the serial sum packer: state encoding and default word width.
package serial_sum_pkg;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_e;
endpackage

// File: rtl/bit_counter.sv
// Saturating up-counter with synchronous clear and load; clear wins over load, load over increment.
module bit_counter #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (inc && (cnt_q != W'(MAX))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/serial_sum_packer.sv
// Packs sum/carry bit pairs from a serial adder into WIDTH-bit words, counting carries,
// with a single held word presented to a ready/valid consumer and a sticky drop flag.
module serial_sum_packer
  import serial_sum_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       bit_valid,
  input  logic                       a_in,
  input  logic                       cout_in,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_word,
  output logic [$clog2(WIDTH+1)-1:0] out_carries,
  output logic                       overflow
);
  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [CW-1:0]    carries_q, carries_d;
  logic             valid_q;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt;
  logic             cnt_clr, cnt_load, cnt_inc;

  bit_counter #(
    .W  (CW),
    .MAX(WIDTH - 1)
  ) u_bit_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .load    (cnt_load),
    .load_val(CW'(1)),
    .inc     (cnt_inc),
    .cnt     (cnt)
  );

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    carries_d = carries_q;
    ovf_d     = ovf_q;
    cnt_clr   = 1'b0;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      IDLE, FILL: begin
        if (bit_valid) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (cnt == CW'(i)) word_d[i] = a_in;
          end
          carries_d = carries_q + CW'(cout_in);
          if (cnt == CW'(WIDTH - 1)) begin
            state_d = HOLD;
            cnt_clr = 1'b1;
          end else begin
            state_d = FILL;
            cnt_inc = 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          // Transfer: the word buffer is reused, so it restarts from zero.
          if (bit_valid) begin
            word_d    = WIDTH'(a_in);
            carries_d = CW'(cout_in);
            cnt_load  = 1'b1;
            state_d   = FILL;
          end else begin
            word_d    = '0;
            carries_d = '0;
            cnt_clr   = 1'b1;
            state_d   = IDLE;
          end
        end else if (bit_valid) begin
          ovf_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      word_q    <= '0;
      carries_q <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      carries_q <= carries_d;
      valid_q   <= (state_d == HOLD);
      ovf_q     <= ovf_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_word    = word_q;
  assign out_carries = carries_q;
  assign overflow    = ovf_q;

`ifdef FORMAL
  logic          f_bit_q, f_seen_q;
  (* anyconst *) logic [CW-1:0] f_idx;

  always_comb begin
    assume (f_idx < CW'(WIDTH));
    if (!rst_n) assume (!bit_valid);
    assert (valid_q == (state_q == HOLD));
    if (rst_n) begin
      assert (cnt < CW'(WIDTH));
      if (state_q == HOLD) assert (carries_q <= CW'(WIDTH));
      else                 assert (carries_q <= cnt);
    end
  end

  restrict property (@(posedge clk) !valid_q |=> $stable(out_ready));

  // Remember the bit written at the chosen index of the current word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_bit_q  <= 1'b0;
      f_seen_q <= 1'b0;
    end else if ((state_q == HOLD) && out_ready) begin
      f_seen_q <= bit_valid && (f_idx == '0);
      f_bit_q  <= a_in;
    end else if (bit_valid && (state_q != HOLD) && (cnt == f_idx)) begin
      f_seen_q <= 1'b1;
      f_bit_q  <= a_in;
    end
  end

  always_comb begin
    if (rst_n && f_seen_q) assert (word_q[f_idx] == f_bit_q);
  end
`endif
endmodule
